sim_monitor: RTL and testbench
==============================

# sim_monitor

Synthesizable run monitor that sits directly downstream of the processor under test in the processor-level testbenches. It snoops the data-memory write port and PC, decodes a mailbox (tohost) protocol that test programs use to report results, and runs watchdog and self-loop detectors. It produces a sticky terminal verdict and statistics that the testbench samples to finish a test.

## Interface
- TOHOST_ADDR, 32'hFFFF_FFF0: word address of the result mailbox.
- TIMEOUT_CYCLES, 10000: cycles without a checkpoint before timeout; minimum 2.
- HANG_CYCLES, 16: consecutive cycles with an unchanged PC that count as a hang; minimum 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- mem_write_en  in  1  data-memory write strobe from the processor.
- mem_addr  in  32  data-memory address.
- mem_write_data  in  32  data-memory write data.
- pc  in  32  current program counter.
- done  out  1  high once any terminal state is reached; sticky.
- pass  out  1  terminal state is PASS.
- fail  out  1  terminal state is FAIL.
- timeout  out  1  terminal state is TIMEOUT.
- hang  out  1  terminal state is HANG.
- fail_code  out  31  mem_write_data[31:1] of the failing mailbox write.
- fail_pc  out  32  pc sampled on the cycle that caused FAIL or HANG.
- checkpoints  out  16  count of checkpoint writes; saturates at 16'hFFFF.
- cycle_count  out  32  cycles spent in RUN; wraps modulo 2^32.

## Operation
- States: RUN, PASS, FAIL, TIMEOUT, HANG. Reset enters RUN. All four other states are terminal and are left only by reset.
- A mailbox write is mem_write_en=1 with mem_addr==TOHOST_ADDR, evaluated in RUN only.
  - Data 32'h1: RUN->PASS.
  - Odd data other than 1: RUN->FAIL; capture fail_code=data[31:1] and fail_pc=pc.
  - Even data, including 0: checkpoint; increment checkpoints and clear the watchdog. State stays RUN.
  - Writes to any other address are ignored.
- Watchdog: counter wd increments each RUN cycle and is cleared by a checkpoint. When wd reaches TIMEOUT_CYCLES-1 with no mailbox write that cycle, RUN->TIMEOUT.
- Hang detector: register prev_pc; counter hc counts consecutive RUN cycles with pc==prev_pc, and any pc change clears it. When hc reaches HANG_CYCLES-1 with no mailbox write that cycle, RUN->HANG and fail_pc=pc.
  - Because tests end with a jump-to-self, they must write the mailbox before looping.
- Same-cycle priority: mailbox write > TIMEOUT > HANG.
- Only one state change per cycle. Outputs and counters are frozen in every terminal state.
- Reset values:
  - state=RUN.
  - All flags=0.
  - fail_code=0, fail_pc=0, checkpoints=0, cycle_count=0, wd=0, hc=0.
  - prev_pc=0. The first post-reset cycle compares pc against 0.

## Timing
- Each verdict flag and done rise on the clock edge that samples the triggering input. They are visible one cycle after the write or the threshold cycle.
- cycle_count increments on every RUN edge, including the edge that leaves RUN. After reset, a PASS on the Nth sampled cycle gives cycle_count=N.
- Reset asserted mid-run or in a terminal state returns everything to reset values on that edge. Inputs are ignored while reset=1.
- Exactly one of pass/fail/timeout/hang is high whenever done=1.

## Test plan
- Pass: reset 2 cycles, then increment pc by 4 each cycle. On cycle 5 write 32'h1 to TOHOST_ADDR. Required: pass=1 and done=1 on the next edge, cycle_count=5, all other flags 0; pass stays high while stimulus continues.
- Fail: write 32'h7 at pc=32'h0040_0010. Required: fail=1, fail_code=3, fail_pc=32'h0040_0010; a later write of 32'h1 leaves state FAIL.
- Timeout: TIMEOUT_CYCLES=20, pc advancing, checkpoint data 32'h2 written at cycle 10. Required: checkpoints=1 and timeout=1 exactly 20 cycles after the checkpoint, not at cycle 20.
- Hang: HANG_CYCLES=4, pc held at 32'h0040_0020 from cycle 3. Required: hang=1 after the 4th identical sample and fail_pc=32'h0040_0020. With a mailbox 32'h1 on that same threshold cycle, pass=1 instead.
- Ignored and saturating writes: a write of 32'h1 to TOHOST_ADDR+4 leaves the state at RUN. 65540 checkpoints give checkpoints=16'hFFFF.
- Reset mid-run: reset asserted for 1 cycle after 3 checkpoints. Required: all outputs 0 on the next edge, and a subsequent pass sequence behaves as in the pass scenario.

Source files
------------

// File: rtl/sim_monitor.sv
// sim_monitor: watches the processor's data-memory write port and PC.
// Test programs report through a tohost mailbox: 1 means pass, any other
// odd value means fail with a code, and even values are checkpoints.
// A watchdog catches runs that stop making progress, and a self-loop
// detector catches a PC that stays on one instruction.
// The verdict is sticky and everything stays frozen until reset.
module sim_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'hFFFF_FFF0,
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter int          HANG_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] pc,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic        hang,
    output logic [30:0] fail_code,
    output logic [31:0] fail_pc,
    output logic [15:0] checkpoints,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT,
        ST_HANG
    } state_t;

    // Thresholds compare against the registered counters, so the verdict
    // lands on the edge that samples the threshold cycle.
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] HC_LIMIT = 32'(HANG_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [30:0] fail_code_reg, fail_code_next;
    logic [31:0] fail_pc_reg, fail_pc_next;
    logic [15:0] checkpoints_reg, checkpoints_next;
    logic [31:0] cycle_count_reg, cycle_count_next;
    logic [31:0] wd_reg, wd_next;
    logic [31:0] hc_reg, hc_next;
    logic [31:0] prev_pc_reg, prev_pc_next;

    logic mailbox_hit;
    logic pc_same;

    // Decode the mailbox write and the self-loop comparison for this cycle.
    always_comb begin
        mailbox_hit = mem_write_en && (mem_addr == TOHOST_ADDR);
        pc_same     = (pc == prev_pc_reg);
    end

    // State and statistics registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            fail_code_reg   <= '0;
            fail_pc_reg     <= '0;
            checkpoints_reg <= '0;
            cycle_count_reg <= '0;
            wd_reg          <= '0;
            hc_reg          <= '0;
            prev_pc_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            fail_code_reg   <= fail_code_next;
            fail_pc_reg     <= fail_pc_next;
            checkpoints_reg <= checkpoints_next;
            cycle_count_reg <= cycle_count_next;
            wd_reg          <= wd_next;
            hc_reg          <= hc_next;
            prev_pc_reg     <= prev_pc_next;
        end
    end

    // Next-state: only RUN does any work; terminal states hold every register.
    // Priority within RUN is mailbox write, then watchdog, then self-loop.
    always_comb begin
        state_next       = state_reg;
        fail_code_next   = fail_code_reg;
        fail_pc_next     = fail_pc_reg;
        checkpoints_next = checkpoints_reg;
        cycle_count_next = cycle_count_reg;
        wd_next          = wd_reg;
        hc_next          = hc_reg;
        prev_pc_next     = prev_pc_reg;

        if (state_reg == ST_RUN) begin
            cycle_count_next = cycle_count_reg + 32'd1;
            wd_next          = wd_reg + 32'd1;
            prev_pc_next     = pc;
            // Saturate the loop counter so a checkpoint written from inside
            // a self-loop cannot push it past the threshold and mask a hang.
            if (pc_same) begin
                hc_next = (hc_reg == HC_LIMIT) ? hc_reg : hc_reg + 32'd1;
            end else begin
                hc_next = '0;
            end

            if (mailbox_hit) begin
                if (mem_write_data == 32'd1) begin
                    state_next = ST_PASS;
                end else if (mem_write_data[0]) begin
                    state_next     = ST_FAIL;
                    fail_code_next = mem_write_data[31:1];
                    fail_pc_next   = pc;
                end else begin
                    wd_next = '0;
                    if (checkpoints_reg != 16'hFFFF) begin
                        checkpoints_next = checkpoints_reg + 16'd1;
                    end
                end
            end else if (wd_reg == WD_LIMIT) begin
                state_next = ST_TIMEOUT;
            end else if (hc_reg == HC_LIMIT) begin
                state_next   = ST_HANG;
                fail_pc_next = pc;
            end
        end
    end

    // Verdict flags are decoded straight from the registered state.
    always_comb begin
        done        = (state_reg != ST_RUN);
        pass        = (state_reg == ST_PASS);
        fail        = (state_reg == ST_FAIL);
        timeout     = (state_reg == ST_TIMEOUT);
        hang        = (state_reg == ST_HANG);
        fail_code   = fail_code_reg;
        fail_pc     = fail_pc_reg;
        checkpoints = checkpoints_reg;
        cycle_count = cycle_count_reg;
    end

endmodule

// File: tb/tb_sim_monitor.sv
// Testbench for sim_monitor: a cycle-level reference model pushes the
// expected outputs onto a scoreboard queue as each input vector is driven;
// the entry is popped and compared once the DUT has taken the edge.
// Scenario checks against fixed values back up the model.
module tb_sim_monitor;

    localparam logic [31:0] TOHOST = 32'hFFFF_FFF0;
    localparam int          T_CYC  = 20;
    localparam int          H_CYC  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write_en = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic [31:0] pc = '0;
    logic        done, pass, fail, timeout, hang;
    logic [30:0] fail_code;
    logic [31:0] fail_pc;
    logic [15:0] checkpoints;
    logic [31:0] cycle_count;

    sim_monitor #(
        .TOHOST_ADDR   (TOHOST),
        .TIMEOUT_CYCLES(T_CYC),
        .HANG_CYCLES   (H_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_write_en  (mem_write_en),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .pc            (pc),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .timeout       (timeout),
        .hang          (hang),
        .fail_code     (fail_code),
        .fail_pc       (fail_pc),
        .checkpoints   (checkpoints),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  flags;   // done, pass, fail, timeout, hang
        logic [30:0] code;
        logic [31:0] fpc;
        logic [15:0] cp;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_passed = 0;
    bit   quiet    = 1'b0;
    logic [31:0] tb_pc = 32'h0040_0000;

    // Reference model state: 0 run, 1 pass, 2 fail, 3 timeout, 4 hang.
    int          m_state  = 0;
    logic [30:0] m_code   = '0;
    logic [31:0] m_fpc    = '0;
    int          m_cp     = 0;
    logic [31:0] m_cyc    = '0;
    int          m_idle   = 0;
    int          m_streak = 0;
    logic [31:0] m_prev   = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic model_step(input logic rst, input logic we, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] cur_pc);
        bit mb;
        if (rst) begin
            m_state = 0; m_code = '0; m_fpc = '0; m_cp = 0;
            m_cyc = '0; m_idle = 0; m_streak = 0; m_prev = '0;
        end else if (m_state == 0) begin
            mb = we && (addr == TOHOST);
            m_cyc = m_cyc + 32'd1;
            if (mb && data == 32'd1) m_state = 1;
            else if (mb && data[0]) begin
                m_state = 2; m_code = data[31:1]; m_fpc = cur_pc;
            end else if (mb) begin
                if (m_cp < 65535) m_cp++;
            end else if (m_idle == T_CYC - 1) m_state = 3;
            else if (m_streak >= H_CYC - 1) begin
                m_state = 4; m_fpc = cur_pc;
            end
            m_idle   = mb ? 0 : m_idle + 1;
            m_streak = (cur_pc == m_prev) ? m_streak + 1 : 0;
            m_prev   = cur_pc;
        end
    endtask

    // One clock: drive inputs, push the model's prediction, compare after the edge.
    task automatic drive(input logic rst, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] cur_pc);
        exp_t e;
        exp_t o;
        reset = rst; mem_write_en = we; mem_addr = addr; mem_write_data = data; pc = cur_pc;
        model_step(rst, we, addr, data, cur_pc);
        e.flags = {m_state != 0, m_state == 1, m_state == 2, m_state == 3, m_state == 4};
        e.code  = m_code;
        e.fpc   = m_fpc;
        e.cp    = 16'(m_cp);
        e.cyc   = m_cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!quiet && (we || rst))
            $display("t=%0t rst=%0b we=%0b addr=%h data=%h pc=%h -> done=%0b p/f/t/h=%0b%0b%0b%0b code=%h fpc=%h cp=%0d cyc=%0d",
                     $time, rst, we, addr, data, cur_pc, done, pass, fail, timeout, hang,
                     fail_code, fail_pc, checkpoints, cycle_count);
        o = sb_q.pop_front();
        check_val("flags", {27'b0, done, pass, fail, timeout, hang}, {27'b0, o.flags});
        check_val("fail_code", {1'b0, fail_code}, {1'b0, o.code});
        check_val("fail_pc", fail_pc, o.fpc);
        check_val("checkpoints", {16'b0, checkpoints}, {16'b0, o.cp});
        check_val("cycle_count", cycle_count, o.cyc);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'h0, 32'h0, tb_pc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, tb_pc);
            tb_pc = tb_pc + 32'd4;
        end
    endtask

    task automatic mailbox(input logic [31:0] data);
        drive(1'b0, 1'b1, TOHOST, data, tb_pc);
        tb_pc = tb_pc + 32'd4;
    endtask

    // Four quiet cycles then a pass write on the fifth sampled cycle.
    task automatic pass_sequence(input string tag);
        idle(4);
        mailbox(32'h1);
        check_val({tag, "_pass"}, {31'b0, pass}, 32'd1);
        check_val({tag, "_done"}, {31'b0, done}, 32'd1);
        check_val({tag, "_cyc"}, cycle_count, 32'd5);
        check_val({tag, "_others"}, {29'b0, fail, timeout, hang}, 32'd0);
    endtask

    initial begin
        // Pass scenario.
        do_reset(2);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_cyc", cycle_count, 32'd0);
        tb_pc = 32'h0040_0000;
        pass_sequence("pass");
        idle(2);
        mailbox(32'h7);
        check_val("pass_sticky", {31'b0, pass}, 32'd1);
        check_val("pass_frozen_cyc", cycle_count, 32'd5);

        // Fail scenario, then a late pass write must not change the verdict.
        do_reset(1);
        tb_pc = 32'h0040_0000;
        idle(4);
        check_val("fail_pc_setup", tb_pc, 32'h0040_0010);
        mailbox(32'h7);
        check_val("fail_flag", {31'b0, fail}, 32'd1);
        check_val("fail_code_val", {1'b0, fail_code}, 32'd3);
        check_val("fail_pc_val", fail_pc, 32'h0040_0010);
        mailbox(32'h1);
        check_val("fail_sticky", {30'b0, fail, pass}, 32'd2);

        // Timeout with a checkpoint on cycle 10: fires 20 cycles later.
        do_reset(1);
        tb_pc = 32'h0040_0000;
        idle(9);
        mailbox(32'h2);
        idle(10);
        check_val("to_not_at_20", {31'b0, timeout}, 32'd0);
        idle(9);
        check_val("to_not_at_29", {31'b0, timeout}, 32'd0);
        idle(1);
        check_val("to_at_30", {31'b0, timeout}, 32'd1);
        check_val("to_cp", {16'b0, checkpoints}, 32'd1);
        check_val("to_cyc", cycle_count, 32'd30);

        // Timeout with no checkpoint at all lands on cycle 20.
        do_reset(1);
        idle(19);
        check_val("to_plain_19", {31'b0, done}, 32'd0);
        idle(1);
        check_val("to_plain_20", {31'b0, timeout}, 32'd1);

        // Hang: pc parked at 0x00400020 from cycle 3.
        do_reset(1);
        tb_pc = 32'h0040_0018;
        idle(2);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0020);
        check_val("hang_early", {31'b0, hang}, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0020);
        check_val("hang_flag", {31'b0, hang}, 32'd1);
        check_val("hang_pc", fail_pc, 32'h0040_0020);

        // Same hang, but a pass write on the threshold cycle wins.
        do_reset(1);
        tb_pc = 32'h0040_0018;
        idle(2);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0020);
        drive(1'b0, 1'b1, TOHOST, 32'h1, 32'h0040_0020);
        check_val("hang_vs_pass", {30'b0, pass, hang}, 32'd2);

        // Ignored writes and checkpoint saturation.
        do_reset(1);
        tb_pc = 32'h0040_0000;
        drive(1'b0, 1'b1, TOHOST + 32'd4, 32'h1, tb_pc);
        tb_pc = tb_pc + 32'd4;
        drive(1'b0, 1'b1, 32'h0000_1000, 32'h7, tb_pc);
        tb_pc = tb_pc + 32'd4;
        check_val("ignored_addr", {31'b0, done}, 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 65540; i++) mailbox(32'(i) << 1);
        quiet = 1'b0;
        check_val("cp_saturated", {16'b0, checkpoints}, 32'h0000_FFFF);
        check_val("cp_still_run", {31'b0, done}, 32'd0);

        // Reset mid-run after three checkpoints; inputs ignored during reset.
        do_reset(1);
        tb_pc = 32'h0040_0000;
        mailbox(32'h0);
        mailbox(32'h4);
        mailbox(32'h6);
        check_val("mid_cp", {16'b0, checkpoints}, 32'd3);
        drive(1'b1, 1'b1, TOHOST, 32'h1, tb_pc);
        check_val("mid_flags", {27'b0, done, pass, fail, timeout, hang}, 32'd0);
        check_val("mid_cp_clr", {16'b0, checkpoints}, 32'd0);
        check_val("mid_cyc_clr", cycle_count, 32'd0);
        pass_sequence("after_rst");

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
